// File: rtl/css_mcu0_el2_lsu_busclk_ctl_if.sv
// LSU bus-clock control bundle. The TLU/PIC side uses master; the clock controller uses slave.
interface css_mcu0_el2_lsu_busclk_ctl_if #(
    parameter int RATIO_W = 3
);
    logic [RATIO_W-1:0] bus_ratio;
    logic               ratio_upd;
    logic               quiesce_req;
    logic               lsu_bus_buffer_empty_any;
    logic               lsu_stbuf_empty_any;
    logic               lsu_bus_clk_en;
    logic [RATIO_W-1:0] ratio_active;
    logic               quiesce_ack;
    logic               drain_busy;

    modport master (
        output bus_ratio, ratio_upd, quiesce_req,
               lsu_bus_buffer_empty_any, lsu_stbuf_empty_any,
        input  lsu_bus_clk_en, ratio_active, quiesce_ack, drain_busy
    );

    modport slave (
        input  bus_ratio, ratio_upd, quiesce_req,
               lsu_bus_buffer_empty_any, lsu_stbuf_empty_any,
        output lsu_bus_clk_en, ratio_active, quiesce_ack, drain_busy
    );
endinterface

// File: rtl/css_mcu0_el2_lsu_busclk_ctl.sv
// LSU bus clock-ratio enable generator plus bus quiesce/drain handshake.
// All outputs registered; ratio changes take effect only at a period boundary or while quiesced.
module css_mcu0_el2_lsu_busclk_ctl #(
    parameter int RATIO_W   = 3,
    parameter int IDLE_HOLD = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    css_mcu0_el2_lsu_busclk_ctl_if.slave          bus
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_QUIESCED = 2'd3;

    localparam logic [3:0] HOLD_LAST = 4'(IDLE_HOLD - 1);

    logic [1:0]         state, state_nxt;
    logic [3:0]         hcnt, hcnt_nxt;
    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] ratio_active;
    logic [RATIO_W-1:0] pend_ratio;
    logic               pend_vld;
    logic               clk_en;
    logic               idle;
    logic               wrap;
    logic               freeze;
    logic               apply;

    assign idle = bus.lsu_bus_buffer_empty_any & bus.lsu_stbuf_empty_any;
    assign wrap = (cnt == ratio_active);

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        case (state)
            ST_RUN: begin
                if (bus.quiesce_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.quiesce_req) begin
                    state_nxt = ST_RUN;
                end else if (idle) begin
                    if (IDLE_HOLD == 1) begin
                        state_nxt = ST_QUIESCED;
                        hcnt_nxt  = 4'd0;
                    end else begin
                        state_nxt = ST_HOLD;
                        hcnt_nxt  = 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                // hcnt counts idle cycles already seen; this cycle is one more
                if (!bus.quiesce_req) begin
                    state_nxt = ST_RUN;
                    hcnt_nxt  = 4'd0;
                end else if (!idle) begin
                    state_nxt = ST_DRAIN;
                    hcnt_nxt  = 4'd0;
                end else if (hcnt == HOLD_LAST) begin
                    state_nxt = ST_QUIESCED;
                    hcnt_nxt  = 4'd0;
                end else begin
                    hcnt_nxt  = hcnt + 4'd1;
                end
            end
            default: begin
                if (!bus.quiesce_req) state_nxt = ST_RUN;
            end
        endcase
    end

    // Freeze on the entry edge too, so the enable never overlaps the ack.
    assign freeze = (state == ST_QUIESCED) || (state_nxt == ST_QUIESCED);
    assign apply  = wrap || freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            hcnt         <= 4'd0;
            cnt          <= '0;
            clk_en       <= 1'b0;
            ratio_active <= '0;
            pend_ratio   <= '0;
            pend_vld     <= 1'b0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;

            if (freeze) begin
                cnt    <= '0;
                clk_en <= 1'b0;
            end else if (wrap) begin
                cnt    <= '0;
                clk_en <= 1'b1;
            end else begin
                cnt    <= cnt + 1'b1;
                clk_en <= 1'b0;
            end

            if (bus.ratio_upd && apply) begin
                ratio_active <= bus.bus_ratio;
                pend_vld     <= 1'b0;
            end else if (bus.ratio_upd) begin
                pend_ratio   <= bus.bus_ratio;
                pend_vld     <= 1'b1;
            end else if (pend_vld && apply) begin
                ratio_active <= pend_ratio;
                pend_vld     <= 1'b0;
            end
        end
    end

    assign bus.lsu_bus_clk_en = clk_en;
    assign bus.ratio_active   = ratio_active;
    assign bus.quiesce_ack    = (state == ST_QUIESCED);
    assign bus.drain_busy     = (state == ST_DRAIN) || (state == ST_HOLD);

endmodule

// File: tb/tb_css_mcu0_el2_lsu_busclk_ctl.sv
// Directed bench: each step drives one cycle of inputs and queues the hand-computed
// outputs expected after that edge; a monitor pops and compares on the falling edge.
module tb_css_mcu0_el2_lsu_busclk_ctl;

    logic clk = 1'b0;
    logic rst;

    css_mcu0_el2_lsu_busclk_ctl_if #(.RATIO_W(3)) busif ();

    css_mcu0_el2_lsu_busclk_ctl #(.RATIO_W(3), .IDLE_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       en;
        logic       ack;
        logic       busy;
        logic [2:0] ra;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, id, act, want);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("lsu_bus_clk_en", e.id, {7'd0, busif.lsu_bus_clk_en}, {7'd0, e.en});
                chk("quiesce_ack",    e.id, {7'd0, busif.quiesce_ack},    {7'd0, e.ack});
                chk("drain_busy",     e.id, {7'd0, busif.drain_busy},     {7'd0, e.busy});
                chk("ratio_active",   e.id, {5'd0, busif.ratio_active},   {5'd0, e.ra});
            end
        end
    end

    // Drive one cycle of inputs, then queue the outputs expected after the edge.
    task automatic step(input logic r, input logic [2:0] br, input logic up, input logic qr,
                        input logic bbe, input logic sbe,
                        input logic e_en, input logic e_ack, input logic e_busy, input logic [2:0] e_ra);
        exp_t e;
        rst                            = r;
        busif.bus_ratio                = br;
        busif.ratio_upd                = up;
        busif.quiesce_req              = qr;
        busif.lsu_bus_buffer_empty_any = bbe;
        busif.lsu_stbuf_empty_any      = sbe;
        @(posedge clk);
        #1;
        step_id++;
        e.id = step_id; e.en = e_en; e.ack = e_ack; e.busy = e_busy; e.ra = e_ra;
        sb.push_back(e);
    endtask

    initial begin
        int wait_cyc;
        // 1: reset, then ratio 0 enables every cycle
        step(1, 0, 0, 0, 1, 1,  0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1,  0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 0);
        // strobe on a wrap cycle applies immediately: ratio 1
        step(0, 1, 1, 0, 1, 1,  1, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 1);
        // 2: mid-period strobe to 3 waits for the wrap, then period 4
        step(0, 3, 1, 0, 1, 1,  0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 3);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 3);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 3);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 3);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 3);
        // pending 5 overwritten by 2 before the wrap
        step(0, 5, 1, 0, 1, 1,  0, 0, 0, 3);
        step(0, 2, 1, 0, 1, 1,  0, 0, 0, 3);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 3);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 2);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 2);
        // 3: quiesce with store buffer busy for 6 cycles
        step(0, 0, 0, 1, 1, 0,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 0,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 0,  1, 0, 1, 2);
        step(0, 0, 0, 1, 1, 0,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 0,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 0,  1, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  1, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  0, 1, 0, 2);
        step(0, 0, 0, 1, 1, 1,  0, 1, 0, 2);
        step(0, 0, 0, 1, 1, 1,  0, 1, 0, 2);
        // 5b: release after ack at ratio 2, first enable 3 cycles later
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 2);
        // 4: bus buffer glitch in HOLD restarts the idle count
        step(0, 0, 0, 1, 1, 1,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  0, 0, 1, 2);
        step(0, 0, 0, 1, 0, 1,  1, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  0, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  1, 0, 1, 2);
        step(0, 0, 0, 1, 1, 1,  0, 1, 0, 2);
        // ratio strobe while quiesced applies at once
        step(0, 1, 1, 1, 1, 1,  0, 1, 0, 1);
        step(0, 0, 0, 1, 1, 1,  0, 1, 0, 1);
        // 6: reset while quiesced, request still high
        step(1, 0, 0, 1, 1, 1,  0, 0, 0, 0);
        // 5a: re-enter drain, set ratio 1, drop request in DRAIN
        step(0, 1, 1, 1, 1, 0,  1, 0, 1, 1);
        step(0, 0, 0, 1, 1, 0,  0, 0, 1, 1);
        step(0, 0, 0, 1, 1, 0,  1, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0,  0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1,  0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1,  1, 0, 0, 1);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_scoreboard got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
